// File: rtl/mix_charnum_if.sv
// Sequencer-side bus of the MIX CHAR/NUM converter: request, operands, results and status.
// The sequencer uses the master modport and the converter uses the slave modport.
interface mix_charnum_if #(
  parameter int BYTE_W = 6,
  parameter int BYTES  = 5
);
  localparam int W = BYTES * BYTE_W;

  logic         start;
  logic         mode;
  logic [W-1:0] in_a;
  logic [W-1:0] in_x;
  logic [W-1:0] out_a;
  logic [W-1:0] out_x;
  logic         busy;
  logic         done;
  logic         ovf;

  modport master (
    output start, mode, in_a, in_x,
    input  out_a, out_x, busy, done, ovf
  );

  modport slave (
    input  start, mode, in_a, in_x,
    output out_a, out_x, busy, done, ovf
  );
endinterface

// File: rtl/mix_charnum.sv
// Iterative MIX CHAR (binary -> decimal character codes) / NUM (character codes -> binary) unit.
// Defining MIX_CHARNUM_FAST_EN makes CHAR retire two double-dabble steps per cycle.
module mix_charnum #(
  parameter int BYTE_W    = 6,
  parameter int BYTES     = 5,
  parameter int CHAR_BASE = 30
) (
  input logic         clk,
  input logic         rst,
  mix_charnum_if.slave bus
);
  localparam int unsigned W     = BYTES * BYTE_W;
  localparam int unsigned D     = 2 * BYTES;
  localparam int unsigned BCD_W = 4 * D;
`ifdef MIX_CHARNUM_FAST_EN
  localparam int unsigned STEPS = 2;
`else
  localparam int unsigned STEPS = 1;
`endif
  localparam int unsigned ITERS_C = (W + STEPS - 1) / STEPS;
  // Binary operand is zero-padded at the top so the step count is a multiple of STEPS;
  // the extra leading zeros shift into an all-zero BCD register and change nothing.
  localparam int unsigned BIN_W   = ITERS_C * STEPS;
  localparam int unsigned CNT_MAX = (ITERS_C > D) ? ITERS_C : D;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, CHAR_RUN, NUM_RUN, FIN} state_t;

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [2*W-1:0]     src_q, src_d;
  logic [W-1:0]       acc_q, acc_d;
  logic               acc_ovf_q, acc_ovf_d;
  logic [W-1:0]       x_q, x_d;
  logic [W-1:0]       out_a_q, out_a_d;
  logic [W-1:0]       out_x_q, out_x_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;

  logic [BCD_W-1:0]   step_bcd;
  logic [BIN_W-1:0]   step_bin;
  logic [BYTE_W-1:0]  cur_byte;
  logic [3:0]         digit;
  logic [W+3:0]       acc_wide;

  function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] bcd, input logic bit_in);
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int unsigned i = 0; i < D; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    return {adj[BCD_W-2:0], bit_in};
  endfunction

  function automatic logic [W-1:0] to_chars(input logic [4*BYTES-1:0] digits);
    logic [W-1:0] r;
    r = '0;
    for (int unsigned j = 0; j < BYTES; j++) begin
      r[j*BYTE_W +: BYTE_W] = BYTE_W'(CHAR_BASE) + BYTE_W'(digits[4*j +: 4]);
    end
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    src_d     = src_q;
    acc_d     = acc_q;
    acc_ovf_d = acc_ovf_q;
    x_d       = x_q;
    out_a_d   = out_a_q;
    out_x_d   = out_x_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;

    step_bcd = bcd_q;
    step_bin = bin_q;
    for (int unsigned s = 0; s < STEPS; s++) begin
      step_bcd = dd_step(step_bcd, step_bin[BIN_W-1]);
      step_bin = step_bin << 1;
    end

    cur_byte = src_q[2*W-1 -: BYTE_W];
    digit    = 4'(cur_byte % BYTE_W'(10));
    acc_wide = ({4'b0, acc_q} << 3) + ({4'b0, acc_q} << 1) + {{W{1'b0}}, digit};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mode_d    = bus.mode;
          bin_d     = BIN_W'(bus.in_a);
          bcd_d     = '0;
          src_d     = {bus.in_a, bus.in_x};
          x_d       = bus.in_x;
          acc_d     = '0;
          acc_ovf_d = 1'b0;
          ovf_d     = 1'b0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = bus.mode ? NUM_RUN : CHAR_RUN;
        end
      end
      CHAR_RUN: begin
        bcd_d = step_bcd;
        bin_d = step_bin;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITERS_C - 1)) state_d = FIN;
      end
      NUM_RUN: begin
        acc_d = acc_wide[W-1:0];
        if (|acc_wide[W+3:W]) acc_ovf_d = 1'b1;
        src_d = src_q << BYTE_W;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(D - 1)) state_d = FIN;
      end
      FIN: begin
        if (!mode_q) begin
          out_a_d = to_chars(bcd_q[BCD_W-1 -: 4*BYTES]);
          out_x_d = to_chars(bcd_q[4*BYTES-1:0]);
          ovf_d   = 1'b0;
        end else begin
          out_a_d = acc_q;
          out_x_d = x_q;
          ovf_d   = acc_ovf_q;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      cnt_q     <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      src_q     <= '0;
      acc_q     <= '0;
      acc_ovf_q <= 1'b0;
      x_q       <= '0;
      out_a_q   <= '0;
      out_x_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      src_q     <= src_d;
      acc_q     <= acc_d;
      acc_ovf_q <= acc_ovf_d;
      x_q       <= x_d;
      out_a_q   <= out_a_d;
      out_x_q   <= out_x_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.out_a = out_a_q;
  assign bus.out_x = out_x_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_mix_charnum.sv
// Directed bench for mix_charnum: CHAR/NUM vectors, overflow, ignored start, mid-run reset.
module tb_mix_charnum;
  localparam int LIMIT = 100;
`ifdef MIX_CHARNUM_FAST_EN
  localparam int CHAR_LAT = 16;
`else
  localparam int CHAR_LAT = 31;
`endif
  localparam int NUM_LAT = 11;

  localparam logic [29:0] C1_IN = 30'o0601111500;
  localparam logic [29:0] C1_A  = {6'd30, 6'd31, 6'd30, 6'd30, 6'd39};
  localparam logic [29:0] C1_X  = {6'd36, 6'd33, 6'd31, 6'd33, 6'd36};
  localparam logic [29:0] C2_IN = 30'd1073741823;
  localparam logic [29:0] C2_A  = {6'd31, 6'd30, 6'd37, 6'd33, 6'd37};
  localparam logic [29:0] C2_X  = {6'd34, 6'd31, 6'd38, 6'd32, 6'd33};
  localparam logic [29:0] N1_A  = {6'd0, 6'd0, 6'd31, 6'd32, 6'd39};
  localparam logic [29:0] N1_X  = {6'd37, 6'd57, 6'd47, 6'd30, 6'd30};
  localparam logic [29:0] N9    = {6'd39, 6'd39, 6'd39, 6'd39, 6'd39};
  localparam logic [29:0] N0    = {6'd30, 6'd30, 6'd30, 6'd30, 6'd30};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   lat;
  int   dn;

  mix_charnum_if #(.BYTE_W(6), .BYTES(5)) bus ();

  mix_charnum #(.BYTE_W(6), .BYTES(5), .CHAR_BASE(30)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulses start for one edge, then waits (bounded) for done; glitch>0 re-pulses start
  // so that it is sampled at start+glitch with different operands.
  task automatic run_op(input logic m, input logic [29:0] a, input logic [29:0] x,
                        input int glitch, output int latency);
    int n;
    bus.start = 1'b1; bus.mode = m; bus.in_a = a; bus.in_x = x;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_on_accept", 64'(bus.busy), 64'd1);
    check("ovf_cleared_on_accept", 64'(bus.ovf), 64'd0);
    latency = -1;
    n = 0;
    while (latency < 0 && n < LIMIT) begin
      if (glitch != 0 && n == glitch - 1) begin
        bus.start = 1'b1; bus.mode = ~m; bus.in_a = '1; bus.in_x = '1;
      end
      @(posedge clk); #1;
      n++;
      bus.start = 1'b0;
      if (bus.done) latency = n;
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.mode = 1'b0; bus.in_a = '0; bus.in_x = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_a", 64'(bus.out_a), 64'd0);
    check("rst_out_x", 64'(bus.out_x), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_ovf", 64'(bus.ovf), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(1'b0, C1_IN, '0, 0, lat);
    check("char1_latency", 64'(lat), 64'(CHAR_LAT));
    check("char1_out_a", 64'(bus.out_a), 64'(C1_A));
    check("char1_out_x", 64'(bus.out_x), 64'(C1_X));
    check("char1_ovf", 64'(bus.ovf), 64'd0);
    check("char1_busy_at_done", 64'(bus.busy), 64'd0);

    // Issued during the done cycle: IDLE already, so it must be taken.
    run_op(1'b0, C2_IN, 30'h2aaaaaaa, 0, lat);
    check("char2_latency", 64'(lat), 64'(CHAR_LAT));
    check("char2_out_a", 64'(bus.out_a), 64'(C2_A));
    check("char2_out_x", 64'(bus.out_x), 64'(C2_X));
    @(posedge clk); #1;
    check("char2_done_one_cycle", 64'(bus.done), 64'd0);
    check("char2_hold_out_a", 64'(bus.out_a), 64'(C2_A));

    run_op(1'b1, N1_A, N1_X, 0, lat);
    check("num1_latency", 64'(lat), 64'(NUM_LAT));
    check("num1_out_a", 64'(bus.out_a), 64'd12977700);
    check("num1_out_x", 64'(bus.out_x), 64'(N1_X));
    check("num1_ovf", 64'(bus.ovf), 64'd0);
    @(posedge clk); #1;

    run_op(1'b1, N9, N9, 0, lat);
    check("num9_latency", 64'(lat), 64'(NUM_LAT));
    check("num9_out_a", 64'(bus.out_a), 64'd336323583);
    check("num9_ovf", 64'(bus.ovf), 64'd1);
    @(posedge clk); #1;
    check("num9_ovf_held", 64'(bus.ovf), 64'd1);

    run_op(1'b1, N0, N0, 0, lat);
    check("num0_out_a", 64'(bus.out_a), 64'd0);
    check("num0_out_x", 64'(bus.out_x), 64'(N0));
    check("num0_ovf", 64'(bus.ovf), 64'd0);
    @(posedge clk); #1;

    run_op(1'b0, C1_IN, '0, 5, lat);
    check("glitch_latency", 64'(lat), 64'(CHAR_LAT));
    check("glitch_out_a", 64'(bus.out_a), 64'(C1_A));
    check("glitch_out_x", 64'(bus.out_x), 64'(C1_X));

    run_op(1'b1, N1_A, N1_X, 0, lat);
    check("after_done_latency", 64'(lat), 64'(NUM_LAT));
    check("after_done_out_a", 64'(bus.out_a), 64'd12977700);
    @(posedge clk); #1;

    bus.start = 1'b1; bus.mode = 1'b0; bus.in_a = C2_IN; bus.in_x = '0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("midrun_hold_out_a", 64'(bus.out_a), 64'd12977700);
    check("midrun_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    check("abort_out_a", 64'(bus.out_a), 64'd0);
    check("abort_out_x", 64'(bus.out_x), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    dn = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done) dn++;
    end
    rst = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.done) dn++;
    end
    check("abort_no_done", 64'(dn), 64'd0);
    check("abort_idle_busy", 64'(bus.busy), 64'd0);

    run_op(1'b0, C1_IN, '0, 0, lat);
    check("fresh_latency", 64'(lat), 64'(CHAR_LAT));
    check("fresh_out_a", 64'(bus.out_a), 64'(C1_A));
    check("fresh_out_x", 64'(bus.out_x), 64'(C1_X));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mix_charnum.md
Name: mix_charnum

Overview:
- Iterative MIX CHAR/NUM conversion unit; supersedes the fixed 30-bit, CHAR-only converter.
- CHAR: binary magnitude of rA becomes 2*BYTES decimal character codes (30+digit), split across rA:rX.
- NUM: character bytes of rA:rX become a binary magnitude in rA.
- Sits beside the ALU and is started by the instruction sequencer. Signs are handled outside this block; only magnitudes pass through it.

Parameters:
- BYTE_W, 6, bits per MIX byte.
- BYTES, 5, bytes per word; word width W = BYTES*BYTE_W, digit count D = 2*BYTES.
- CHAR_BASE, 30, character code of digit 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; accepted only when busy=0.
- mode  in  1  0=CHAR, 1=NUM; sampled with start.
- in_a  in  W  rA magnitude; sampled with start.
- in_x  in  W  rX magnitude; sampled with start; CHAR ignores it.
- out_a  out  W  result rA magnitude.
- out_x  out  W  result rX magnitude; NUM drives in_x unchanged.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse, results valid.
- ovf  out  1  NUM result exceeded 2^W-1; valid with done, held until next start.

Behaviour:
- Reset (async): state IDLE; out_a=0, out_x=0, busy=0, done=0, ovf=0. Reset mid-conversion aborts the conversion with no done pulse.
- States: IDLE, CHAR_RUN, NUM_RUN, FIN.
- start=1 at edge k in IDLE:
  - Latch mode, in_a and in_x.
  - Clear the accumulators and ovf.
  - Go to CHAR_RUN or NUM_RUN; busy=1 from edge k.
- start while busy=1 is ignored; no queueing.
- CHAR_RUN (shift-add-3 / double-dabble):
  - Each cycle, every 4-bit BCD digit >=5 gets +3, then {bcd,bin} shifts left 1.
  - W iterations (edges k+1..k+W), then FIN.
- NUM_RUN:
  - One byte per cycle, most significant first: rA byte1..byteB, then rX byte1..byteB.
  - digit = byte mod 10; acc = (acc*10 + digit) mod 2^W.
  - Set ovf sticky if any intermediate true value >= 2^W.
  - D iterations, then FIN.
- FIN, one cycle, then IDLE with busy=0:
  - CHAR: out_a = char of digits D-1..BYTES, out_x = char of digits BYTES-1..0; each byte = CHAR_BASE + digit, leading zeros included. ovf=0.
  - NUM: out_a = acc, out_x = latched in_x.
  - done=1 for exactly that cycle.
- Latency start->done: CHAR W+1 cycles, NUM D+1 cycles (31 and 11 at defaults).
- Outputs hold their values until the next accepted start. Outputs are not updated during busy; intermediate state lives in internal registers.
- A new start is accepted on the cycle after done (IDLE).
- D digits always cover 2^W-1 because 100^B > 64^B; no CHAR overflow exists.

Optional Feature:
- Macro MIX_CHARNUM_FAST_EN.
- Defined: CHAR_RUN performs two correct-then-shift steps per cycle, giving ceil(W/2) iterations and CHAR latency ceil(W/2)+1 (16 at defaults). Results are identical.
- Undefined: one bit per cycle as above.
- NUM is unaffected either way.

Test Plan:
- CHAR, in_a=30'o0601111500 (100963136) -> done at start+31; out_a=30'o3637363647 (30,31,30,30,39), out_x=30'o4441374144 (36,33,31,33,36), ovf=0.
- CHAR, in_a=2^30-1 (1073741823) -> bytes 31,30,37,33,37 / 34,31,38,32,33. With MIX_CHARNUM_FAST_EN, the same bytes with done at start+16.
- NUM, in_a bytes 0,0,31,32,39 and in_x bytes 37,57,47,30,30 -> out_a=12977700, out_x unchanged, ovf=0, done at start+11.
- NUM, all bytes 39 (9999999999) -> out_a=336323583, ovf=1. A following NUM on all bytes 30 -> out_a=0, ovf=0.
- start pulsed again at start+5 during CHAR -> ignored; single done, results as the first scenario. A start on the cycle after done is accepted.
- rst asserted at start+10 of CHAR -> outputs 0 immediately, busy=0, no done. A fresh conversion after release completes correctly.
